tw_horizontal_tx: RTL and testbench

// - Transmit end of the horizontal twiddle-update bus feeding the stage-0 twiddle ROM buffers.
// - Holds NUM_SETS local sets of 4 x 128-bit twiddle entries; on start, streams one set as 64-bit beats.
// - Upper halves [127:64] go out tagged ROM2_w=1, lower halves [63:0] tagged ROM2_w=2.
// - Each burst is strictly contiguous: the receiver's 0..3 slot counter clears on any idle beat.

---
 rtl/tw_bus_pkg.sv | 36 +++
 rtl/tw_tx_table.sv | 38 +++
 rtl/tw_horizontal_tx.sv | 144 ++++++++++++++
 tb/tb_tw_horizontal_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tw_bus_pkg.sv
// Shared definitions for the horizontal twiddle-update bus: widths, beat tags,
// transfer modes and the transmitter FSM states.
package tw_bus_pkg;

  localparam int P_WIDTH  = 128;
  localparam int HORIZ_DW = P_WIDTH / 2;
  localparam int ENTRIES  = 4;
  localparam int ADDR_W   = 2;

  localparam logic [P_WIDTH-1:0] RESET_ENTRY = {64'h1, 64'h1};

  typedef logic [1:0] rom2w_t;
  localparam rom2w_t W_IDLE = 2'd0;
  localparam rom2w_t W_HI   = 2'd1;
  localparam rom2w_t W_LO   = 2'd2;

  typedef enum logic [1:0] {
    MODE_NOP   = 2'b00,
    MODE_HI    = 2'b01,
    MODE_LO    = 2'b10,
    MODE_HI_LO = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_HI,
    ST_GAP,
    ST_SEND_LO,
    ST_DONE
  } state_e;

  function automatic int set_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tw_tx_table.sv
// Local twiddle store: NUM_SETS sets of ENTRIES x P_WIDTH entries, one write
// port and one combinational read port.
module tw_tx_table
  import tw_bus_pkg::*;
#(
  parameter  int NUM_SETS = 4,
  localparam int SET_W    = set_width(NUM_SETS)
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [SET_W-1:0]   wr_set_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [P_WIDTH-1:0] wdata_i,
  input  logic [SET_W-1:0]   rd_set_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [P_WIDTH-1:0] rd_data_o
);

  logic [P_WIDTH-1:0] mem_q [NUM_SETS][ENTRIES];

  // NOTE: this store is reset because the receiver relies on the known
  // pattern after reset; a plain RAM would normally be left unreset.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          mem_q[s][e] <= RESET_ENTRY;
        end
      end
    end else if (we_i) begin
      mem_q[wr_set_i][wr_addr_i] <= wdata_i;
    end
  end

  assign rd_data_o = mem_q[rd_set_i][rd_addr_i];

endmodule

// File: rtl/tw_horizontal_tx.sv
// Transmit end of the horizontal twiddle-update bus: streams one stored set as
// contiguous 64-bit beats, upper halves tagged 1 and lower halves tagged 2.
module tw_horizontal_tx
  import tw_bus_pkg::*;
#(
  parameter  int NUM_SETS   = 4,
  parameter  int GAP_CYCLES = 0,
  localparam int SET_W      = set_width(NUM_SETS)
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SET_W-1:0]    set_sel,
  input  logic [1:0]          mode,
  input  logic                tbl_we,
  input  logic [SET_W-1:0]    tbl_set,
  input  logic [ADDR_W-1:0]   tbl_addr,
  input  logic [P_WIDTH-1:0]  tbl_wdata,
  output logic [HORIZ_DW-1:0] horizontal_data_out,
  output logic [1:0]          ROM2_w,
  output logic                busy,
  output logic                done,
  output logic                tbl_err
);

  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   beat_q, beat_d;
  logic [3:0]          gap_q, gap_d;
  logic [SET_W-1:0]    set_q, set_d;
  mode_e               mode_q, mode_d;
  logic [HORIZ_DW-1:0] data_q, data_d;
  rom2w_t              w_q, w_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q;
  logic [P_WIDTH-1:0]  rd_entry;
  logic                tbl_reject;

  // The set being streamed is frozen for the whole transfer.
  assign tbl_reject = (state_q != ST_IDLE) && (tbl_set == set_q);

  tw_tx_table #(.NUM_SETS(NUM_SETS)) u_table (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .we_i      (tbl_we && !tbl_reject),
    .wr_set_i  (tbl_set),
    .wr_addr_i (tbl_addr),
    .wdata_i   (tbl_wdata),
    .rd_set_i  (set_q),
    .rd_addr_i (beat_q),
    .rd_data_o (rd_entry)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no branch leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    set_d   = set_q;
    mode_d  = mode_q;
    data_d  = '0;
    w_d     = W_IDLE;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The done pulse is shown while the FSM already sits in IDLE; that
        // cycle still belongs to the finished transfer and ignores start.
        if (start && (mode_e'(mode) != MODE_NOP) && !done_q) begin
          set_d   = set_sel;
          mode_d  = mode_e'(mode);
          beat_d  = '0;
          state_d = (mode_e'(mode) == MODE_LO) ? ST_SEND_LO : ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        data_d = rd_entry[P_WIDTH-1:HORIZ_DW];
        w_d    = W_HI;
        busy_d = 1'b1;
        beat_d = beat_q + 1'b1;
        if (beat_q == 2'd3) begin
          gap_d = '0;
          if (mode_q == MODE_HI_LO) state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_SEND_LO;
          else                      state_d = ST_DONE;
        end
      end
      ST_GAP: begin
        busy_d = 1'b1;
        if (gap_q == GAP_LAST) state_d = ST_SEND_LO;
        else                   gap_d   = gap_q + 1'b1;
      end
      ST_SEND_LO: begin
        data_d = rd_entry[HORIZ_DW-1:0];
        w_d    = W_LO;
        busy_d = 1'b1;
        beat_d = beat_q + 1'b1;
        if (beat_q == 2'd3) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      gap_q   <= '0;
      set_q   <= '0;
      mode_q  <= MODE_NOP;
      data_q  <= '0;
      w_q     <= W_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values,
      // independent of statement order.
      state_q <= state_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      set_q   <= set_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      w_q     <= w_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= tbl_we && tbl_reject;
    end
  end

  assign horizontal_data_out = data_q;
  assign ROM2_w              = w_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign tbl_err             = err_q;

endmodule

// File: tb/tb_tw_horizontal_tx.sv
// Directed bench for tw_horizontal_tx: expected beats are queued from a table
// model when a transfer is started and popped by a monitor as beats appear.
module tb_tw_horizontal_tx;
  import tw_bus_pkg::*;

  typedef struct packed {
    logic [1:0]  w;
    logic [63:0] d;
    logic        b;
  } beat_t;

  logic         CLK = 1'b0;
  logic         rst_n;
  logic         start, start_g;
  logic [1:0]   set_sel, mode;
  logic         tbl_we;
  logic [1:0]   tbl_set, tbl_addr;
  logic [127:0] tbl_wdata;
  logic [63:0]  data0, data_g;
  logic [1:0]   w0, w_g;
  logic         busy0, busy_g, done0, done_g, err0, err_g;

  int checks = 0;
  int errors = 0;
  int beats_seen = 0;
  int done_cnt = 0;
  beat_t exp_q[$];
  beat_t gq[$];
  logic [127:0] model [4][4];

  always #5 CLK = ~CLK;

  tw_horizontal_tx #(.NUM_SETS(4), .GAP_CYCLES(0)) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .set_sel(set_sel), .mode(mode),
    .tbl_we(tbl_we), .tbl_set(tbl_set), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .horizontal_data_out(data0), .ROM2_w(w0), .busy(busy0), .done(done0), .tbl_err(err0)
  );

  tw_horizontal_tx #(.NUM_SETS(4), .GAP_CYCLES(3)) dut_g (
    .CLK(CLK), .rst_n(rst_n), .start(start_g), .set_sel(set_sel), .mode(mode),
    .tbl_we(tbl_we), .tbl_set(tbl_set), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .horizontal_data_out(data_g), .ROM2_w(w_g), .busy(busy_g), .done(done_g), .tbl_err(err_g)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_beat(input logic [1:0] w, input logic [63:0] d);
    beat_t e;
    e.w = w; e.d = d; e.b = 1'b1;
    exp_q.push_back(e);
  endfunction

  function automatic void push_set(input logic [1:0] s, input logic [1:0] md);
    if (md[0]) for (int k = 0; k < 4; k++) push_beat(W_HI, model[s][k][127:64]);
    if (md[1]) for (int k = 0; k < 4; k++) push_beat(W_LO, model[s][k][63:0]);
  endfunction

  function automatic void reset_model();
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 4; k++) model[s][k] = {64'h1, 64'h1};
  endfunction

  task automatic write_entry(input logic [1:0] s, input logic [1:0] a, input logic [127:0] d);
    tbl_we = 1'b1; tbl_set = s; tbl_addr = a; tbl_wdata = d;
    @(posedge CLK); #1 tbl_we = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (done0) begin cyc = i; break; end
    end
    check({tag, "_done_seen"}, 128'(cyc >= 0), 128'(1));
  endtask

  task automatic run_burst(input string tag, input logic [1:0] s, input logic [1:0] md, input int n_beats);
    int busy_n;
    int done_at;
    busy_n = 0; done_at = -1;
    set_sel = s; mode = md; start = 1'b1;
    @(posedge CLK); #1 start = 1'b0; tbl_we = 1'b0;
    @(negedge CLK);
    check({tag, "_lat0"}, 128'({w0, busy0}), 128'(0));
    for (int i = 0; i < 60 && done_at < 0; i++) begin
      @(negedge CLK);
      if (done0) done_at = i;
      else if (busy0) busy_n++;
    end
    check({tag, "_busy"}, 128'(busy_n), 128'(n_beats));
    check({tag, "_done_at"}, 128'(done_at), 128'(n_beats));
    check({tag, "_drain"}, 128'(exp_q.size()), 128'(0));
    @(negedge CLK);
    check({tag, "_done_pulse"}, 128'({done0, busy0, w0}), 128'(0));
  endtask

  always @(negedge CLK) begin : mon
    beat_t e;
    if (rst_n === 1'b1) begin
      if (done0) done_cnt++;
      if (w0 != W_IDLE) begin
        beats_seen++;
        if (exp_q.size() == 0) check("extra_beat", 128'(w0), 128'(W_IDLE));
        else begin
          e = exp_q.pop_front();
          check("beat", 128'({w0, data0}), 128'({e.w, e.d}));
        end
      end
    end
  end

  initial begin : stim
    int cyc, b0, d0, busy_n;
    beat_t e;
    reset_model();
    rst_n = 1'b0; start = 1'b0; start_g = 1'b0; set_sel = '0; mode = '0;
    tbl_we = 1'b0; tbl_set = '0; tbl_addr = '0; tbl_wdata = '0;

    @(negedge CLK);
    check("rst_w", 128'(w0), 128'(W_IDLE));
    check("rst_data", 128'(data0), 128'(0));
    check("rst_flags", 128'({busy0, done0, err0}), 128'(0));
    @(posedge CLK); #1 rst_n = 1'b1;
    @(posedge CLK); #1;

    push_set(0, 2'b01);
    run_burst("hi_only", 0, 2'b01, 4);
    push_set(0, 2'b10);
    run_burst("lo_only", 0, 2'b10, 4);

    b0 = beats_seen; d0 = done_cnt; busy_n = 0;
    set_sel = 0; mode = 2'b00; start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    repeat (12) begin @(negedge CLK); if (busy0) busy_n++; end
    check("nop_beats", 128'(beats_seen - b0), 128'(0));
    check("nop_done", 128'(done_cnt - d0), 128'(0));
    check("nop_busy", 128'(busy_n), 128'(0));

    for (int k = 0; k < 4; k++) begin
      model[1][k] = {64'hA0 + 64'(k), 64'hB0 + 64'(k)};
      write_entry(1, 2'(k), model[1][k]);
    end
    push_set(1, 2'b11);
    run_burst("hi_lo", 1, 2'b11, 8);

    for (int k = 0; k < 4; k++) begin e.w = W_HI; e.d = model[1][k][127:64]; e.b = 1'b1; gq.push_back(e); end
    for (int k = 0; k < 3; k++) begin e.w = W_IDLE; e.d = '0; e.b = 1'b1; gq.push_back(e); end
    for (int k = 0; k < 4; k++) begin e.w = W_LO; e.d = model[1][k][63:0]; e.b = 1'b1; gq.push_back(e); end
    set_sel = 1; mode = 2'b11; start_g = 1'b1;
    @(posedge CLK); #1 start_g = 1'b0;
    @(negedge CLK);
    check("gap_lat0", 128'({w_g, busy_g}), 128'(0));
    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      e = gq.pop_front();
      check($sformatf("gap_cycle%0d", i), 128'({w_g, data_g, busy_g}), 128'({e.w, e.d, e.b}));
    end
    @(negedge CLK);
    check("gap_done", 128'({done_g, busy_g, w_g, err_g}), 128'(5'b10000));

    push_set(1, 2'b11);
    b0 = beats_seen; d0 = done_cnt;
    set_sel = 1; mode = 2'b11; start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    wait_done("restart", cyc);
    start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    repeat (15) @(negedge CLK);
    check("restart_beats", 128'(beats_seen - b0), 128'(8));
    check("restart_done", 128'(done_cnt - d0), 128'(1));
    check("restart_drain", 128'(exp_q.size()), 128'(0));

    push_set(1, 2'b11);
    set_sel = 1; mode = 2'b11; start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    @(posedge CLK); #1;
    write_entry(1, 0, {64'hDEAD, 64'hBEEF});
    @(negedge CLK);
    check("err_same_set", 128'(err0), 128'(1));
    model[2][0] = {64'h2222, 64'h3333};
    write_entry(2, 0, model[2][0]);
    @(negedge CLK);
    check("err_other_set", 128'(err0), 128'(0));
    wait_done("reject", cyc);
    check("reject_drain", 128'(exp_q.size()), 128'(0));
    @(posedge CLK); #1;
    push_set(1, 2'b01);
    run_burst("after_reject", 1, 2'b01, 4);
    push_set(2, 2'b10);
    run_burst("set2_lo", 2, 2'b10, 4);

    model[3][0] = {64'hC0, 64'hD0};
    tbl_we = 1'b1; tbl_set = 3; tbl_addr = 0; tbl_wdata = model[3][0];
    push_set(3, 2'b01);
    run_burst("same_cycle", 3, 2'b01, 4);

    for (int k = 0; k < 4; k++) push_beat(W_HI, model[1][k][127:64]);
    for (int k = 0; k < 2; k++) push_beat(W_LO, model[1][k][63:0]);
    set_sel = 1; mode = 2'b11; start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_out", 128'({w0, data0, busy0, done0, err0}), 128'(0));
    check("rst_mid_popped", 128'(exp_q.size()), 128'(0));
    @(posedge CLK); #1 rst_n = 1'b1;
    reset_model();
    @(posedge CLK); #1;
    push_set(1, 2'b11);
    run_burst("post_rst", 1, 2'b11, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
